// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EXE stage.
// Runs mult/multu/div/divu with a fixed multi-cycle latency, executes mthi/mtlo in
// one cycle, and holds the architectural HI/LO registers.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp_E,
    input  logic [31:0] RS_E,
    input  logic [31:0] RT_E,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dz;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_tmp;
    logic [31:0]        r_lo_tmp;

    logic               w_is_md;
    logic               w_is_div;
    logic               w_start;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_ovf;
    logic [31:0]        w_rt_safe;
    logic [31:0]        w_quo_s;
    logic [31:0]        w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;
    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;

    // Launch decode; Start is deliberately combinational for hazard control.
    always_comb begin
        w_is_md  = (MDOp_E == OP_MULT) || (MDOp_E == OP_MULTU) ||
                   (MDOp_E == OP_DIV)  || (MDOp_E == OP_DIVU);
        w_is_div = (MDOp_E == OP_DIV) || (MDOp_E == OP_DIVU);
        w_start  = w_is_md && !r_busy && !Req;
    end

    // Result datapath; divisor replaced by 1 for div-by-zero (result discarded)
    // and for 0x80000000 / -1 (x/1 yields the required quotient and zero remainder).
    always_comb begin
        w_prod_s  = {{32{RS_E[31]}}, RS_E} * {{32{RT_E[31]}}, RT_E};
        w_prod_u  = {32'd0, RS_E} * {32'd0, RT_E};
        w_ovf     = (RS_E == 32'h8000_0000) && (RT_E == 32'hFFFF_FFFF);
        w_rt_safe = ((RT_E == 32'd0) || w_ovf) ? 32'd1 : RT_E;
        w_quo_s   = $signed(RS_E) / $signed(w_rt_safe);
        w_rem_s   = $signed(RS_E) % $signed(w_rt_safe);
        w_quo_u   = RS_E / w_rt_safe;
        w_rem_u   = RS_E % w_rt_safe;
        w_hi_res  = 32'd0;
        w_lo_res  = 32'd0;
        case (MDOp_E)
            OP_MULT:  begin w_hi_res = w_prod_s[63:32]; w_lo_res = w_prod_s[31:0]; end
            OP_MULTU: begin w_hi_res = w_prod_u[63:32]; w_lo_res = w_prod_u[31:0]; end
            OP_DIV:   begin w_hi_res = w_rem_s;         w_lo_res = w_quo_s;        end
            OP_DIVU:  begin w_hi_res = w_rem_u;         w_lo_res = w_quo_u;        end
            default:  begin w_hi_res = 32'd0;           w_lo_res = 32'd0;          end
        endcase
    end

    // IDLE/RUN control, latency counter and HI/LO register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_dz     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_hi_tmp <= w_hi_res;
                        r_lo_tmp <= w_lo_res;
                        r_cnt    <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_dz     <= w_is_div && (RT_E == 32'd0);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else if (!Req) begin
                        if (MDOp_E == OP_MTHI) begin
                            r_hi <= RS_E;
                        end else if (MDOp_E == OP_MTLO) begin
                            r_lo <= RS_E;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (!r_dz) begin
                            r_hi <= r_hi_tmp;
                            r_lo <= r_lo_tmp;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Start = w_start;
    assign Busy  = r_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  MDOp_E;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDOp_E (MDOp_E),
        .RS_E   (RS_E),
        .RT_E   (RT_E),
        .Req    (Req),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with Busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; MDOp_E = 4'd0; RS_E = 32'd0; RT_E = 32'd0; Req = 1'b0;
        step(); step();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        reset = 1'b1;
        step();
        checks++;
        if (Start !== 1'b0) begin
            errors++;
            $display("FAIL reset_start: Start=%b, required 0", Start);
        end
    endtask

    // Launch one op, check Start and the busy length, then HI/LO.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n;
        MDOp_E = op; RS_E = a; RT_E = b;
        #1;
        checks++;
        if (Start !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: Start=%b, required 1", name, Start);
        end
        step();
        MDOp_E = 4'd0; RS_E = 32'd0; RT_E = 32'd0;
        count_busy(n);
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s_latency: busy cycles=%0d, required %0d", name, n, lat);
        end
        checks++;
        if (HI !== ehi || LO !== elo) begin
            errors++;
            $display("FAIL %s_result: HI=%h LO=%h, required HI=%h LO=%h", name, HI, LO, ehi, elo);
        end
    endtask

    task automatic test_mult();
        run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        run_op("div",     4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",    4'd4, 32'd7,         32'd2, 10, 32'd1,         32'd3);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        int n;
        MDOp_E = 4'd5; RS_E = 32'h1234; step();
        MDOp_E = 4'd6; RS_E = 32'h5678; step();
        MDOp_E = 4'd3; RS_E = 32'd99; RT_E = 32'd0;
        step();
        // mthi during RUN must be ignored
        MDOp_E = 4'd5; RS_E = 32'hAAAA_AAAA;
        step(); step();
        MDOp_E = 4'd0; RS_E = 32'd0;
        count_busy(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL dz_latency: remaining busy cycles=%0d, required 8", n);
        end
        checks++;
        if (HI !== 32'h1234 || LO !== 32'h5678) begin
            errors++;
            $display("FAIL dz_result: HI=%h LO=%h, required HI=00001234 LO=00005678", HI, LO);
        end
    endtask

    task automatic test_req_gating();
        MDOp_E = 4'd1; RS_E = 32'd5; RT_E = 32'd5; Req = 1'b1;
        #1;
        checks++;
        if (Start !== 1'b0) begin
            errors++;
            $display("FAIL req_start: Start=%b, required 0", Start);
        end
        step();
        Req = 1'b0; MDOp_E = 4'd0;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'h5678) begin
            errors++;
            $display("FAIL req_nolaunch: Busy=%b HI=%h LO=%h, required 0/00001234/00005678", Busy, HI, LO);
        end
        MDOp_E = 4'd9;
        #1;
        checks++;
        if (Start !== 1'b0) begin
            errors++;
            $display("FAIL op9_start: Start=%b, required 0", Start);
        end
        MDOp_E = 4'd0;
    endtask

    task automatic test_back_to_back();
        int n;
        int bad_start;
        MDOp_E = 4'd1; RS_E = 32'd2; RT_E = 32'd3;
        #1;
        step();
        n = 0; bad_start = 0;
        while (Busy && n < 40) begin
            if (Start !== 1'b0) bad_start++;
            n++;
            step();
        end
        checks++;
        if (n != 5 || bad_start != 0) begin
            errors++;
            $display("FAIL b2b_run: busy=%0d start_in_run=%0d, required 5/0", n, bad_start);
        end
        checks++;
        if (Start !== 1'b1 || HI !== 32'd0 || LO !== 32'd6) begin
            errors++;
            $display("FAIL b2b_done: Start=%b HI=%h LO=%h, required 1/0/6", Start, HI, LO);
        end
        step();
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_relaunch: Busy=%b, required 1", Busy);
        end
        MDOp_E = 4'd0;
        count_busy(n);
    endtask

    task automatic test_async_reset();
        MDOp_E = 4'd4; RS_E = 32'd100; RT_E = 32'd7;
        step();
        MDOp_E = 4'd0;
        step(); step();
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        step(); step();
        reset = 1'b1;
        run_op("post_reset", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
    endtask

    task automatic test_mthi_mtlo();
        MDOp_E = 4'd5; RS_E = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (Start !== 1'b0) begin
            errors++;
            $display("FAIL mthi_start: Start=%b, required 0", Start);
        end
        step();
        MDOp_E = 4'd6; RS_E = 32'd1;
        checks++;
        if (HI !== 32'hDEAD_BEEF || LO !== 32'd42 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: HI=%h LO=%h Busy=%b, required deadbeef/0000002a/0", HI, LO, Busy);
        end
        step();
        MDOp_E = 4'd0;
        checks++;
        if (HI !== 32'hDEAD_BEEF || LO !== 32'd1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: HI=%h LO=%h Busy=%b, required deadbeef/00000001/0", HI, LO, Busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_req_gating();
        test_back_to_back();
        test_async_reset();
        test_mthi_mtlo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EXE stage of the 5-stage MIPS pipeline. It executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo in one cycle, and holds the architectural HI/LO registers. It produces the `Start` and `Busy` signals that hazard control uses to stall any md instruction in D. It also supplies HI/LO to the E-stage result mux for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, 5: number of cycles `Busy` stays high for mult/multu (must be ≥1).
- `DIV_CYCLES`, 10: number of cycles `Busy` stays high for div/divu (must be ≥1).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `MDOp_E` in 4: md operation of the E-stage instruction. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–15 are treated as none.
- `RS_E` in 32: forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- `RT_E` in 32: forwarded rt value (divisor / multiplier).
- `Req` in 1: exception/interrupt taken this cycle; suppresses any launch or write.
- `Start` out 1: combinational; high when `MDOp_E` ∈ {1,2,3,4}, `!Busy` and `!Req`.
- `Busy` out 1: registered; high while an operation is in flight.
- `HI` out 32: architectural HI register.
- `LO` out 32: architectural LO register.

## Operation
- States: IDLE (`Busy`=0) and RUN (`Busy`=1). A down-counter `cnt` sized for `max(MULT_CYCLES, DIV_CYCLES)`.
- **IDLE, launch.** On an edge with `Start`=1:
  - compute the result into internal `hi_tmp`/`lo_tmp`;
  - latch `cnt` = `MULT_CYCLES` (op 1, 2) or `DIV_CYCLES` (op 3, 4);
  - set a `dz` flag when the op is a divide and `RT_E`==0;
  - go to RUN.
- **IDLE, mthi/mtlo.** `MDOp_E`=5 or 6 with `Req`=0: write `RS_E` into HI or LO at the next edge. `Busy` stays 0 and `Start` stays 0.
- **RUN.** Each edge decrements `cnt`. On the edge where `cnt` goes 1→0:
  - `Busy` falls;
  - HI←`hi_tmp` and LO←`lo_tmp`, unless `dz` is set, in which case HI/LO are left unchanged.
- **RUN, ignored inputs.** Any `MDOp_E` is ignored, including 5 and 6; hazard control keeps md instructions out of E while `Busy`. `Start` is forced to 0 so a stale decode cannot relaunch.
- **Arithmetic.**
  - mult: signed 32×32→64. multu: unsigned. HI = bits [63:32], LO = bits [31:0].
  - div: signed; LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0.
- **Req.** Gates off `Start` and mthi/mtlo in the same cycle. `Req` during RUN does not cancel the in-flight op: the op belongs to an older, already-committed instruction.

## Timing
- Reset values: `Busy`=0, `cnt`=0, HI=0, LO=0, `dz`=0, `hi_tmp`/`lo_tmp`=0. `Start` follows its inputs combinationally.
- Launch at edge E0 gives `Busy`=1 from just after E0 to just after E_N (N = op latency), i.e. exactly N cycles high. New HI/LO are visible after E_N.
- First possible relaunch is at edge E_N+1; `Start` is valid again in the cycle after `Busy` falls.
- mthi/mtlo: the value is visible on HI/LO one cycle after the edge that samples it.
- Async reset during RUN: `Busy`=0 and HI/LO=0 immediately; the pending result is discarded; the unit returns to IDLE.
- Reset deassertion is synchronised by the system. The first launch is legal at the first edge after release.

## Test plan
- **mult launch.** Apply mult, `RS_E`=0xFFFFFFFE, `RT_E`=3, one cycle. Expect `Start`=1 that cycle, then `Busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu and the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- **div/divu.** div with -7, 2: `Busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with 7, 2: LO=3, HI=1.
- **Divide by zero.** Preload HI=0x1234 and LO=0x5678 via mthi/mtlo, then div by 0. Expect `Busy` high 10 cycles and HI/LO unchanged afterwards.
- **Req gating and back-to-back.** mult with `Req`=1: expect `Start`=0, `Busy` stays 0, HI/LO unchanged. Then hold mult on `MDOp_E` continuously: expect `Start`=0 throughout RUN, and relaunch in the first cycle after `Busy` falls.
- **Async reset mid-op.** Assert `reset` low 3 cycles into a div, off-edge. Expect `Busy`, HI and LO to go to 0 without waiting for a clock edge; the next mult after release completes normally.
- **mthi/mtlo while idle.** mthi 0xDEADBEEF then mtlo 0x1 on consecutive cycles. Expect HI=0xDEADBEEF then LO=0x1, each one cycle after its sampling edge, with `Busy` never asserted.
